// File: rtl/rx_packet_ctrl.sv
// Receive packet sequencer between the SIE Rx bit processor and the Rx FIFO.
// Every byte strobed in by the bit processor is captured first and decoded
// one cycle later, so the handshake, the PID check and the FIFO write all
// work from registered values. Payload bytes reach the FIFO two cycles after
// their strobe. Per-packet status (PID, byte count, error flags) stays
// readable from the done pulse until the controller is armed again.
module rx_packet_ctrl #(
  parameter int TIMEOUT_W     = 16,
  parameter int MAX_PKT_BYTES = 64,
  parameter int CNT_W         = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxPktStart,
  input  logic [TIMEOUT_W-1:0] rxTimeout,
  input  logic [7:0]           RxByteIn,
  input  logic [7:0]           RxCtrlIn,
  input  logic                 rxByteWEn,
  output logic                 rxByteRdy,
  output logic [7:0]           fifoData,
  output logic                 fifoWEn,
  input  logic                 fifoFull,
  output logic [3:0]           rxPID,
  output logic [CNT_W-1:0]     rxByteCount,
  output logic                 rxPIDErr,
  output logic                 rxBitStuffErr,
  output logic                 rxOverflow,
  output logic                 rxTimedOut,
  output logic                 rxPktDone,
  output logic                 rxBusy
);

  // Control codes the bit processor puts on RxCtrlIn.
  localparam logic [7:0] DATA_START           = 8'h00;
  localparam logic [7:0] DATA_STOP            = 8'h01;
  localparam logic [7:0] DATA_STREAM          = 8'h02;
  localparam logic [7:0] DATA_BIT_STUFF_ERROR = 8'h03;

  localparam logic [CNT_W-1:0]     MAX_CNT   = CNT_W'(MAX_PKT_BYTES);
  localparam logic [TIMEOUT_W-1:0] TIMER_ONE = TIMEOUT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_WAIT_PID,
    S_WAIT_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 byte_vld_q, byte_vld_d;
  logic [7:0]           byte_q, byte_d;
  logic [7:0]           ctrl_q, ctrl_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 timer_en_q, timer_en_d;
  logic [3:0]           pid_q, pid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pid_err_q, pid_err_d;
  logic                 bse_q, bse_d;
  logic                 ovf_q, ovf_d;
  logic                 timed_out_q, timed_out_d;

  // Decode of the byte captured on the previous cycle.
  logic got_start, got_stop, got_stream, got_bse;
  assign got_start  = byte_vld_q && (ctrl_q == DATA_START);
  assign got_stop   = byte_vld_q && (ctrl_q == DATA_STOP);
  assign got_stream = byte_vld_q && (ctrl_q == DATA_STREAM);
  assign got_bse    = byte_vld_q && (ctrl_q == DATA_BIT_STUFF_ERROR);

  // A START strobed in the expiry cycle is still in flight; let it win.
  logic start_in_flight;
  logic expire;
  assign start_in_flight = rxByteWEn && (RxCtrlIn == DATA_START);
  assign expire          = timer_en_q && (timer_q <= TIMER_ONE) && !start_in_flight;

  // The current WRITE can go to the FIFO only with space and byte budget left.
  logic room;
  assign room = !fifoFull && (cnt_q < MAX_CNT);

  // State register.
  // NOTE: sequential blocks use non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode from the captured byte, the timer and the arm pulse.
  // NOTE: each always_comb assigns a default to every output first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (rxPktStart) state_d = S_WAIT_START;
      S_WAIT_START: begin
        if (got_start)             state_d = S_WAIT_PID;
        else if (got_bse || expire) state_d = S_DONE;
      end
      S_WAIT_PID: begin
        if (got_stream)               state_d = S_WAIT_DATA;
        else if (got_stop || got_bse) state_d = S_DONE;
      end
      S_WAIT_DATA: begin
        if (got_stream)               state_d = S_WRITE;
        else if (got_stop || got_bse) state_d = S_DONE;
        else if (got_start)           state_d = S_WAIT_PID;
      end
      S_WRITE:      state_d = S_WAIT_DATA;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Handshake, FIFO strobe and packet-level outputs decoded from state.
  always_comb begin
    rxByteRdy = 1'b0;
    fifoWEn   = 1'b0;
    rxPktDone = 1'b0;
    rxBusy    = 1'b0;
    case (state_q)
      S_IDLE:      rxByteRdy = !byte_vld_q;
      S_WAIT_START,
      S_WAIT_PID,
      S_WAIT_DATA: begin
        rxByteRdy = !byte_vld_q;
        rxBusy    = 1'b1;
      end
      S_WRITE: begin
        fifoWEn = room;
        rxBusy  = 1'b1;
      end
      S_DONE:      rxPktDone = 1'b1;
      default:     rxByteRdy = 1'b0;
    endcase
  end

  // Byte capture, timeout timer, byte counter and sticky status flags.
  always_comb begin
    byte_vld_d  = rxByteWEn;
    byte_d      = rxByteWEn ? RxByteIn : byte_q;
    ctrl_d      = rxByteWEn ? RxCtrlIn : ctrl_q;
    timer_d     = timer_q;
    timer_en_d  = timer_en_q;
    pid_d       = pid_q;
    cnt_d       = cnt_q;
    pid_err_d   = pid_err_q;
    bse_d       = bse_q;
    ovf_d       = ovf_q;
    timed_out_d = timed_out_q;
    case (state_q)
      S_IDLE: begin
        if (rxPktStart) begin
          // Load one less so the done pulse lands rxTimeout cycles after arming.
          timer_d     = rxTimeout - TIMER_ONE;
          timer_en_d  = |rxTimeout;
          pid_d       = 4'h0;
          cnt_d       = '0;
          pid_err_d   = 1'b0;
          bse_d       = 1'b0;
          ovf_d       = 1'b0;
          timed_out_d = 1'b0;
        end
      end
      S_WAIT_START: begin
        if (timer_q != '0) timer_d = timer_q - TIMER_ONE;
        if (got_bse)                     bse_d       = 1'b1;
        else if (!got_start && expire)   timed_out_d = 1'b1;
      end
      S_WAIT_PID: begin
        if (got_stream) begin
          pid_d     = byte_q[3:0];
          pid_err_d = (byte_q[3:0] != ~byte_q[7:4]);
        end else if (got_stop) begin
          pid_err_d = 1'b1;
        end else if (got_bse) begin
          bse_d = 1'b1;
        end
      end
      S_WAIT_DATA: begin
        if (got_bse)        bse_d = 1'b1;
        else if (got_start) cnt_d = '0;
      end
      S_WRITE: begin
        if (room) cnt_d = cnt_q + CNT_W'(1);
        else      ovf_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  // NOTE: every register here is reset, including the captured byte, so all
  // outputs show defined values the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_vld_q  <= 1'b0;
      byte_q      <= 8'h00;
      ctrl_q      <= 8'h00;
      timer_q     <= '0;
      timer_en_q  <= 1'b0;
      pid_q       <= 4'h0;
      cnt_q       <= '0;
      pid_err_q   <= 1'b0;
      bse_q       <= 1'b0;
      ovf_q       <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      byte_vld_q  <= byte_vld_d;
      byte_q      <= byte_d;
      ctrl_q      <= ctrl_d;
      timer_q     <= timer_d;
      timer_en_q  <= timer_en_d;
      pid_q       <= pid_d;
      cnt_q       <= cnt_d;
      pid_err_q   <= pid_err_d;
      bse_q       <= bse_d;
      ovf_q       <= ovf_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign fifoData      = byte_q;
  assign rxPID         = pid_q;
  assign rxByteCount   = cnt_q;
  assign rxPIDErr      = pid_err_q;
  assign rxBitStuffErr = bse_q;
  assign rxOverflow    = ovf_q;
  assign rxTimedOut    = timed_out_q;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Bench for rx_packet_ctrl: directed scenarios plus randomized packets
// checked against a protocol-level model of what each packet should produce.
module tb_rx_packet_ctrl;

  localparam int TIMEOUT_W = 16;
  localparam int MAX_PKT_BYTES = 64;
  localparam int CNT_W = 7;

  localparam logic [7:0] C_START  = 8'h00;
  localparam logic [7:0] C_STOP   = 8'h01;
  localparam logic [7:0] C_STREAM = 8'h02;
  localparam logic [7:0] C_BSE    = 8'h03;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxPktStart = 1'b0;
  logic [TIMEOUT_W-1:0] rxTimeout = '0;
  logic [7:0] RxByteIn = 8'h00;
  logic [7:0] RxCtrlIn = 8'h00;
  logic rxByteWEn = 1'b0;
  logic fifoFull = 1'b0;
  logic rxByteRdy, fifoWEn, rxPIDErr, rxBitStuffErr, rxOverflow, rxTimedOut, rxPktDone, rxBusy;
  logic [7:0] fifoData;
  logic [3:0] rxPID;
  logic [CNT_W-1:0] rxByteCount;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wen_cyc = 0;
  int done_cnt = 0;
  logic [7:0] got_q[$];
  int lat_q[$];

  // Stimulus list for one packet and the model's expectations for it.
  logic [7:0] ev_c[$];
  logic [7:0] ev_d[$];
  logic       ev_f[$];
  logic [7:0] exp_bytes[$];
  logic [3:0] m_pid;
  logic       m_have_pid, m_pid_err, m_bse, m_ovf;
  int         m_count;

  rx_packet_ctrl #(.TIMEOUT_W(TIMEOUT_W), .MAX_PKT_BYTES(MAX_PKT_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rxPktStart(rxPktStart), .rxTimeout(rxTimeout),
    .RxByteIn(RxByteIn), .RxCtrlIn(RxCtrlIn), .rxByteWEn(rxByteWEn), .rxByteRdy(rxByteRdy),
    .fifoData(fifoData), .fifoWEn(fifoWEn), .fifoFull(fifoFull), .rxPID(rxPID),
    .rxByteCount(rxByteCount), .rxPIDErr(rxPIDErr), .rxBitStuffErr(rxBitStuffErr),
    .rxOverflow(rxOverflow), .rxTimedOut(rxTimedOut), .rxPktDone(rxPktDone), .rxBusy(rxBusy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Collect FIFO writes, their strobe-to-write latency and done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifoWEn) begin
        got_q.push_back(fifoData);
        lat_q.push_back(cyc - wen_cyc);
      end
      if (rxPktDone) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [TIMEOUT_W-1:0] t);
    got_q.delete();
    lat_q.delete();
    done_cnt = 0;
    rxTimeout = t;
    rxPktStart = 1'b1;
    tick();
    rxPktStart = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] d, input logic f);
    int n = 0;
    while (!rxByteRdy && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (rxByteRdy !== 1'b1) begin
      $display("FAIL send_rdy_wait rxByteRdy=%b want=1 ctrl=%0h", rxByteRdy, c);
      bad++;
    end
    RxCtrlIn = c;
    RxByteIn = d;
    fifoFull = f;
    rxByteWEn = 1'b1;
    wen_cyc = cyc;
    tick();
    rxByteWEn = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (done_cnt == 0) begin
      $display("FAIL %s no rxPktDone within %0d cycles", name, budget);
      bad++;
    end
  endtask

  task automatic push_ev(input logic [7:0] c, input logic [7:0] d, input logic f);
    ev_c.push_back(c);
    ev_d.push_back(d);
    ev_f.push_back(f);
  endtask

  // Protocol-level reading of a byte list: first START opens the packet, the
  // first STREAM after it is the PID, later STREAMs are payload until STOP or
  // bit-stuff error; a START inside the payload begins the packet again.
  task automatic run_model();
    bit started = 0;
    bit in_pkt = 0;
    exp_bytes.delete();
    m_pid = 4'h0; m_have_pid = 0; m_pid_err = 0; m_bse = 0; m_ovf = 0; m_count = 0;
    for (int i = 0; i < ev_c.size(); i++) begin
      if (!started) begin
        if (ev_c[i] == C_START) started = 1;
        else if (ev_c[i] == C_BSE) begin m_bse = 1; break; end
      end else if (!in_pkt) begin
        if (ev_c[i] == C_STREAM) begin
          m_pid = ev_d[i][3:0];
          m_pid_err = (ev_d[i][3:0] != ~ev_d[i][7:4]);
          m_have_pid = 1;
          in_pkt = 1;
        end else if (ev_c[i] == C_STOP) begin m_pid_err = 1; break; end
        else if (ev_c[i] == C_BSE) begin m_bse = 1; break; end
      end else begin
        if (ev_c[i] == C_STREAM) begin
          if (ev_f[i] || m_count >= MAX_PKT_BYTES) m_ovf = 1;
          else begin exp_bytes.push_back(ev_d[i]); m_count++; end
        end else if (ev_c[i] == C_STOP) break;
        else if (ev_c[i] == C_BSE) begin m_bse = 1; break; end
        else if (ev_c[i] == C_START) begin in_pkt = 0; m_count = 0; end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({rxByteRdy, fifoWEn, rxPktDone, rxBusy, rxPIDErr, rxBitStuffErr, rxOverflow, rxTimedOut} !== 8'b1000_0000) begin
      $display("FAIL reset_ctrl got=%b want=10000000",
               {rxByteRdy, fifoWEn, rxPktDone, rxBusy, rxPIDErr, rxBitStuffErr, rxOverflow, rxTimedOut});
      bad++;
    end
    total++;
    if ({rxPID, rxByteCount, fifoData} !== 19'd0) begin
      $display("FAIL reset_data pid=%0h cnt=%0d data=%0h want all 0", rxPID, rxByteCount, fifoData);
      bad++;
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    arm(0);
    total++;
    if (rxBusy !== 1'b1) begin $display("FAIL basic_busy got=%b want=1", rxBusy); bad++; end
    send(C_START, 8'h00, 0);
    send(C_STREAM, 8'hC3, 0);
    send(C_STREAM, 8'h11, 0);
    send(C_STREAM, 8'h22, 0);
    rxPktStart = 1'b1;  // while busy: must be ignored
    tick();
    rxPktStart = 1'b0;
    send(C_STOP, 8'h00, 0);
    wait_done(50, "basic_done");
    total++;
    if (got_q.size() != 2 || got_q[0] !== 8'h11 || got_q[1] !== 8'h22) begin
      $display("FAIL basic_fifo got size=%0d want 2 bytes 11,22", got_q.size());
      bad++;
    end
    total++;
    if (rxPID !== 4'h3 || rxByteCount !== 7'd2) begin
      $display("FAIL basic_status pid=%0h cnt=%0d want pid=3 cnt=2", rxPID, rxByteCount);
      bad++;
    end
    total++;
    if ({rxPIDErr, rxBitStuffErr, rxOverflow, rxTimedOut} !== 4'b0000) begin
      $display("FAIL basic_flags got=%b want=0000", {rxPIDErr, rxBitStuffErr, rxOverflow, rxTimedOut});
      bad++;
    end
    total++;
    if (lat_q.size() != 2 || lat_q[0] != 2 || lat_q[1] != 2) begin
      $display("FAIL basic_latency n=%0d first=%0d want 2 writes at latency 2",
               lat_q.size(), (lat_q.size() > 0) ? lat_q[0] : -1);
      bad++;
    end
    repeat (5) tick();
    total++;
    if (done_cnt != 1 || rxBusy !== 1'b0) begin
      $display("FAIL basic_one_done done=%0d busy=%b want done=1 busy=0", done_cnt, rxBusy);
      bad++;
    end
  endtask

  task automatic test_pid_err();
    arm(0);
    send(C_START, 8'h00, 0);
    send(C_STREAM, 8'hC4, 0);
    send(C_STREAM, 8'h5A, 0);
    send(C_STOP, 8'h00, 0);
    wait_done(50, "piderr_done");
    total++;
    if (rxPIDErr !== 1'b1 || rxPID !== 4'h4) begin
      $display("FAIL piderr_flag err=%b pid=%0h want err=1 pid=4", rxPIDErr, rxPID);
      bad++;
    end
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A || rxByteCount !== 7'd1) begin
      $display("FAIL piderr_payload size=%0d cnt=%0d want one byte 5a cnt=1", got_q.size(), rxByteCount);
      bad++;
    end
  endtask

  task automatic test_timeout();
    int n = 1;
    arm(10);
    while (!rxPktDone && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (!rxPktDone || n != 10) begin
      $display("FAIL timeout_latency done=%b cycles=%0d want done at 10", rxPktDone, n);
      bad++;
    end
    total++;
    if (rxTimedOut !== 1'b1 || rxPIDErr !== 1'b0) begin
      $display("FAIL timeout_flag timedout=%b piderr=%b want 1,0", rxTimedOut, rxPIDErr);
      bad++;
    end
    tick();
    arm(0);
    repeat (300) tick();
    total++;
    if (done_cnt != 0 || rxBusy !== 1'b1) begin
      $display("FAIL timeout_zero done=%0d busy=%b want done=0 busy=1", done_cnt, rxBusy);
      bad++;
    end
    send(C_START, 8'h00, 0);
    send(C_STREAM, 8'hC3, 0);
    send(C_STOP, 8'h00, 0);
    wait_done(50, "timeout_zero_done");
    total++;
    if (rxTimedOut !== 1'b0) begin $display("FAIL timeout_zero_flag got=%b want=0", rxTimedOut); bad++; end
  endtask

  task automatic test_overflow();
    arm(0);
    send(C_START, 8'h00, 0);
    send(C_STREAM, 8'hC3, 0);
    send(C_STREAM, 8'hA1, 0);
    send(C_STREAM, 8'hA2, 1);
    send(C_STREAM, 8'hA3, 0);
    send(C_STOP, 8'h00, 0);
    wait_done(50, "ovf_full_done");
    total++;
    if (got_q.size() != 2 || got_q[0] !== 8'hA1 || got_q[1] !== 8'hA3 ||
        rxByteCount !== 7'd2 || rxOverflow !== 1'b1) begin
      $display("FAIL ovf_full size=%0d cnt=%0d ovf=%b want bytes a1,a3 cnt=2 ovf=1",
               got_q.size(), rxByteCount, rxOverflow);
      bad++;
    end
    arm(0);
    send(C_START, 8'h00, 0);
    send(C_STREAM, 8'hC3, 0);
    for (int i = 0; i < 67; i++) send(C_STREAM, 8'(i), 0);
    send(C_STOP, 8'h00, 0);
    wait_done(100, "ovf_limit_done");
    total++;
    if (rxByteCount !== 7'd64 || rxOverflow !== 1'b1 || got_q.size() != 64) begin
      $display("FAIL ovf_limit cnt=%0d ovf=%b writes=%0d want 64,1,64", rxByteCount, rxOverflow, got_q.size());
      bad++;
    end
    total++;
    if (got_q.size() == 64 && (got_q[0] !== 8'd0 || got_q[63] !== 8'd63)) begin
      $display("FAIL ovf_limit_data first=%0h last=%0h want 0,3f", got_q[0], got_q[63]);
      bad++;
    end
  endtask

  task automatic test_bitstuff();
    arm(0);
    send(C_START, 8'h00, 0);
    send(C_STREAM, 8'hD2, 0);
    send(C_STREAM, 8'h55, 0);
    send(C_BSE, 8'h00, 0);
    wait_done(50, "bse_done");
    total++;
    if (rxBitStuffErr !== 1'b1 || rxByteCount !== 7'd1 || rxPIDErr !== 1'b0) begin
      $display("FAIL bse_status bse=%b cnt=%0d piderr=%b want 1,1,0", rxBitStuffErr, rxByteCount, rxPIDErr);
      bad++;
    end
    arm(0);
    total++;
    if ({rxPIDErr, rxBitStuffErr, rxOverflow, rxTimedOut} !== 4'b0000 || rxByteCount !== 7'd0) begin
      $display("FAIL bse_rearm flags=%b cnt=%0d want 0000 cnt=0",
               {rxPIDErr, rxBitStuffErr, rxOverflow, rxTimedOut}, rxByteCount);
      bad++;
    end
    send(C_START, 8'h00, 0);
    send(C_STREAM, 8'hC3, 0);
    send(C_STOP, 8'h00, 0);
    wait_done(50, "bse_clean_done");
  endtask

  task automatic test_start_on_done();
    int n = 0;
    arm(0);
    send(C_START, 8'h00, 0);
    send(C_STOP, 8'h00, 0);
    while (!rxPktDone && n < 20) begin
      tick();
      n++;
    end
    rxPktStart = 1'b1;
    tick();
    rxPktStart = 1'b0;
    tick();
    total++;
    if (rxBusy !== 1'b0 || rxPIDErr !== 1'b1) begin
      $display("FAIL start_on_done busy=%b piderr=%b want busy=0 piderr=1", rxBusy, rxPIDErr);
      bad++;
    end
  endtask

  task automatic test_reset_mid();
    arm(0);
    send(C_START, 8'h00, 0);
    send(C_STREAM, 8'hC3, 0);
    send(C_STREAM, 8'h77, 0);
    tick();
    total++;
    if (fifoWEn !== 1'b1) begin $display("FAIL rstmid_in_write fifoWEn=%b want=1", fifoWEn); bad++; end
    rst_n = 1'b0;
    #1;
    total++;
    if ({rxByteRdy, fifoWEn, rxPktDone, rxBusy, rxPIDErr, rxBitStuffErr, rxOverflow, rxTimedOut} !== 8'b1000_0000 ||
        rxByteCount !== 7'd0 || rxPID !== 4'h0) begin
      $display("FAIL rstmid_outputs ctrl=%b cnt=%0d pid=%0h want 10000000,0,0",
               {rxByteRdy, fifoWEn, rxPktDone, rxBusy, rxPIDErr, rxBitStuffErr, rxOverflow, rxTimedOut},
               rxByteCount, rxPID);
      bad++;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (done_cnt != 0) begin $display("FAIL rstmid_no_done done=%0d want=0", done_cnt); bad++; end
    arm(0);
    send(C_START, 8'h00, 0);
    send(C_STREAM, 8'hC3, 0);
    send(C_STREAM, 8'h99, 0);
    send(C_STOP, 8'h00, 0);
    wait_done(50, "rstmid_clean_done");
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h99 || rxByteCount !== 7'd1 ||
        {rxPIDErr, rxBitStuffErr, rxOverflow, rxTimedOut} !== 4'b0000) begin
      $display("FAIL rstmid_clean size=%0d cnt=%0d want one byte 99 cnt=1 no flags", got_q.size(), rxByteCount);
      bad++;
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 40; p++) begin
      int len;
      bit restart;
      logic [3:0] pv;
      ev_c.delete(); ev_d.delete(); ev_f.delete();
      if ($urandom_range(0, 3) == 0) push_ev(8'($urandom_range(4, 255)), 8'($urandom), 0);
      push_ev(C_START, 8'h00, 0);
      pv = 4'($urandom_range(0, 15));
      push_ev(C_STREAM, ($urandom_range(0, 1) == 0) ? {~pv, pv} : 8'($urandom), 0);
      len = $urandom_range(0, 6);
      if ($urandom_range(0, 9) == 0) len = $urandom_range(62, 68);
      restart = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) push_ev(8'($urandom_range(4, 255)), 8'($urandom), 0);
        push_ev(C_STREAM, 8'($urandom), ($urandom_range(0, 4) == 0));
        if (restart && i == len / 2) begin
          push_ev(C_START, 8'h00, 0);
          push_ev(C_STREAM, 8'($urandom), 0);
        end
      end
      push_ev(($urandom_range(0, 3) == 0) ? C_BSE : C_STOP, 8'h00, 0);
      run_model();
      arm(0);
      for (int i = 0; i < ev_c.size(); i++) send(ev_c[i], ev_d[i], ev_f[i]);
      wait_done(100, "rand_done");
      total++;
      if (got_q != exp_bytes) begin
        $display("FAIL rand_fifo pkt=%0d writes=%0d want=%0d (contents differ or count)", p, got_q.size(), exp_bytes.size());
        bad++;
      end
      total++;
      if (int'(rxByteCount) != m_count || rxOverflow !== m_ovf || rxBitStuffErr !== m_bse || rxPIDErr !== m_pid_err) begin
        $display("FAIL rand_status pkt=%0d cnt=%0d ovf=%b bse=%b piderr=%b want %0d,%b,%b,%b",
                 p, rxByteCount, rxOverflow, rxBitStuffErr, rxPIDErr, m_count, m_ovf, m_bse, m_pid_err);
        bad++;
      end
      if (m_have_pid) begin
        total++;
        if (rxPID !== m_pid) begin
          $display("FAIL rand_pid pkt=%0d got=%0h want=%0h", p, rxPID, m_pid);
          bad++;
        end
      end
      fifoFull = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pid_err();
    test_timeout();
    test_overflow();
    test_bitstuff();
    test_start_on_done();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
